aes256_enc_arbiter: RTL and testbench
=====================================

Name: aes256_enc_arbiter

Overview:
- Shares one AES256 encryption core between two requesters, each with its own key bank.
- Takes 128-bit plaintext blocks from requesters over valid/ready channels and grants the core round-robin.
- Launches the core with a one-cycle start pulse, waits for its done pulse, and returns ciphertext to the granted requester.
- A watchdog timer soft-resets a hung core and returns an error response.

Parameters:
- TIMEOUT_CYC, 1023: max cycles in BUSY before declaring the core hung (nominal core latency ≈ 330 cycles).
- RST_CYC, 4: cycles core_resetn is held low during recovery.
- TMR_W, 10: width of the watchdog counter; must satisfy 2^TMR_W ≥ TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  2  per-requester block valid.
- req_data  in  2x128  per-requester plaintext.
- req_ready  out  2  per-requester accept (combinational, at most one bit high).
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  128  ciphertext, shared by both requesters.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- core_start  out  1  to core ctrl_dataIn_enc.
- core_dataIn  out  128  to core enc_dataIn.
- core_done  in  1  from core ctrl_dataOut_enc.
- core_dataOut  in  128  from core enc_dataOut.
- core_resetn  out  1  core reset, registered.
- key_bank  out  1  key-ROM bank select; concatenated with the core's enc_keyAddr.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Single clock. Reset is synchronous and active-low; the block samples resetn on the rising edge of clk.
- Reset values:
  - state=IDLE; rsp_valid=0; rsp_data=0; rsp_err=0.
  - core_start=0; core_dataIn=0; core_resetn=0; key_bank=0; busy=0.
  - last_grant=1, so requester 0 wins first.
- core_resetn goes to 1 on the first cycle after resetn is released.
- States: IDLE, LAUNCH, BUSY, RESP, RECOVER.
- IDLE:
  - Grant g is chosen from req_valid. If one bit is high, that requester wins. If both are high, g = ~last_grant.
  - req_ready[g] is asserted in the same cycle; the handshake completes that cycle.
  - On the handshake: latch req_data[g] into core_dataIn, latch key_bank=g, go to LAUNCH.
  - req_ready is 0 in every other state.
- LAUNCH:
  - core_start=1 for exactly this one cycle; the register resets it to 0 on the next edge.
  - Clear the timer, go to BUSY.
  - core_dataIn and key_bank are held stable from LAUNCH until the block re-enters IDLE.
- BUSY:
  - Timer increments each cycle.
  - If core_done=1: capture core_dataOut into rsp_data, set rsp_err=0, go to RESP.
  - Else if timer == TIMEOUT_CYC-1: go to RECOVER.
  - If core_done and timeout occur in the same cycle, core_done wins.
- RECOVER:
  - core_resetn=0 for RST_CYC cycles, then back to 1.
  - Then set rsp_data=0, rsp_err=1, go to RESP.
- RESP:
  - rsp_valid[key_bank]=1, holding rsp_data and rsp_err stable until rsp_ready[key_bank]=1.
  - On that handshake: rsp_valid=0, last_grant=key_bank, go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
- core_done outside BUSY is ignored; no state or data change.
- Back-to-back: the earliest new grant is the IDLE cycle after the RESP handshake, so there is at least one idle cycle between jobs.
- resetn low mid-operation:
  - Any pending job and response is dropped silently; nothing is sent to either requester.
  - core_resetn is forced to 0 while resetn is low, so the core is reset too.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.

Test Plan:
- Single job:
  - Stimulus: key bank 0 loaded with the FIPS-197 C.3 key 000102…1f; req_valid=01, req_data[0]=00112233445566778899aabbccddeeff.
  - Expected: req_ready=01 the same cycle; core_start high exactly 1 cycle, one cycle later; key_bank=0; rsp_valid=01 with rsp_data=8ea2b7ca516745bfeafc49904b496089, rsp_err=0.
- Contention:
  - Stimulus: req_valid=11 held continuously, rsp_ready=11.
  - Expected: grant order 0,1,0,1; key_bank follows the grant; rsp_valid never has both bits set.
- Response backpressure:
  - Stimulus: rsp_ready[0]=0 for 20 cycles after rsp_valid[0] rises.
  - Expected: rsp_valid and rsp_data stable for all 20 cycles; req_ready=00 throughout.
  - Stimulus: a stray rsp_ready[1]=1 pulse during that window.
  - Expected: ignored.
- Timeout:
  - Stimulus: core model never asserts core_done.
  - Expected: after TIMEOUT_CYC BUSY cycles, core_resetn low for exactly 4 cycles; then rsp_valid[g]=1 with rsp_err=1, rsp_data=0.
  - Stimulus: next job with a working core.
  - Expected: completes normally.
- Edge cases:
  - Stimulus: core_done and timeout in the same cycle. Expected: normal response with rsp_err=0.
  - Stimulus: spurious core_done in IDLE. Expected: no effect.
- Mid-operation reset:
  - Stimulus: resetn=0 for 2 cycles while in BUSY.
  - Expected: all outputs at reset values; no response issued; core_resetn=0 during reset.
  - Stimulus: after release, req_valid=11.
  - Expected: requester 0 granted first.

Source files
------------

// File: rtl/aes256_enc_arbiter.sv
// Two-requester round-robin front end for a shared AES-256 encrypt core.
// A watchdog soft-resets a hung core and answers the job with an error.
module aes256_enc_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned RST_CYC     = 4,
  parameter int unsigned TMR_W       = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        req_valid,
  input  logic [1:0][127:0] req_data,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [127:0]      rsp_data,
  output logic              rsp_err,
  output logic              core_start,
  output logic [127:0]      core_dataIn,
  input  logic              core_done,
  input  logic [127:0]      core_dataOut,
  output logic              core_resetn,
  output logic              key_bank,
  output logic              busy
);

  localparam int unsigned RCNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_RESP,
    S_RECOVER
  } state_e;

  state_e            state_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [RCNT_W-1:0] rcnt_q;
  logic              last_grant_q;
  logic [1:0]        rsp_valid_q;
  logic [127:0]      rsp_data_q;
  logic              rsp_err_q;
  logic              core_start_q;
  logic [127:0]      core_dataIn_q;
  logic              core_resetn_q;
  logic              key_bank_q;
  logic              busy_q;
  logic              gnt_c;

  // Single requester wins outright; on contention the one not served last wins.
  always_comb begin
    gnt_c = req_valid[1];
    if (req_valid == 2'b11) gnt_c = ~last_grant_q;
  end

  assign req_ready = (resetn && (state_q == S_IDLE) && (req_valid != 2'b00))
                     ? (gnt_c ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      tmr_q         <= '0;
      rcnt_q        <= '0;
      last_grant_q  <= 1'b1;
      rsp_valid_q   <= 2'b00;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      core_start_q  <= 1'b0;
      core_dataIn_q <= '0;
      core_resetn_q <= 1'b0;
      key_bank_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      core_start_q  <= 1'b0;
      core_resetn_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (req_valid != 2'b00) begin
            core_dataIn_q <= req_data[gnt_c];
            key_bank_q    <= gnt_c;
            core_start_q  <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tmr_q   <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          tmr_q <= tmr_q + 1'b1;
          // A done arriving on the timeout cycle still counts as success.
          if (core_done) begin
            rsp_data_q              <= core_dataOut;
            rsp_err_q               <= 1'b0;
            rsp_valid_q[key_bank_q] <= 1'b1;
            state_q                 <= S_RESP;
          end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            core_resetn_q <= 1'b0;
            rcnt_q        <= '0;
            state_q       <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          if (rcnt_q == RCNT_W'(RST_CYC - 1)) begin
            rsp_data_q              <= '0;
            rsp_err_q               <= 1'b1;
            rsp_valid_q[key_bank_q] <= 1'b1;
            state_q                 <= S_RESP;
          end else begin
            core_resetn_q <= 1'b0;
            rcnt_q        <= rcnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready[key_bank_q]) begin
            rsp_valid_q  <= 2'b00;
            last_grant_q <= key_bank_q;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign core_start  = core_start_q;
  assign core_dataIn = core_dataIn_q;
  assign core_resetn = core_resetn_q;
  assign key_bank    = key_bank_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_aes256_enc_arbiter.sv
// Bench for aes256_enc_arbiter: behavioural core stand-in, job table with a
// response scoreboard, plus hand sequences for spurious done and mid-job reset.
module tb_aes256_enc_arbiter;

  localparam int unsigned TIMEOUT_CYC = 1023;
  localparam int unsigned RST_CYC     = 4;
  localparam int unsigned NV          = 11;
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_FIPS = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic              clk = 1'b0;
  logic              resetn;
  logic [1:0]        req_valid;
  logic [1:0][127:0] req_data;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [127:0]      rsp_data;
  logic              rsp_err;
  logic              core_start;
  logic [127:0]      core_dataIn;
  logic              core_done = 1'b0;
  logic [127:0]      core_dataOut = '0;
  logic              core_resetn;
  logic              key_bank;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]   vld;
    logic [127:0] d0;
    logic [127:0] d1;
    int           lat;
    int           stall;
    logic [1:0]   exp_gnt;
  } vec_t;

  typedef struct {
    logic         g;
    logic [127:0] data;
    logic         err;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb[$];

  aes256_enc_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .RST_CYC(RST_CYC), .TMR_W(10)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_start(core_start), .core_dataIn(core_dataIn), .core_done(core_done),
    .core_dataOut(core_dataOut), .core_resetn(core_resetn), .key_bank(key_bank), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: the arbiter is data-transparent, so only the FIPS-197 C.3 pair is real.
  function automatic logic [127:0] aes_mock(input logic [127:0] d, input logic bank);
    if (d == PT_FIPS && !bank) return CT_FIPS;
    return {d[63:0], d[127:64]} ^ (bank ? {4{32'h5a5a_c3c3}} : {4{32'h0f1e_2d3c}});
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core model: done pulses core_lat cycles after the start cycle; core_lat=0 never finishes.
  int           core_lat  = 20;
  bit           spur_done = 1'b0;
  int           core_cnt  = 0;
  logic [127:0] core_pend = '0;
  always @(negedge clk) begin
    if (!core_resetn) begin
      core_cnt  = 0;
      core_done = 1'b0;
    end else if (core_start) begin
      core_cnt  = core_lat;
      core_pend = aes_mock(core_dataIn, key_bank);
      core_done = 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt  = core_cnt - 1;
      core_done = (core_cnt == 0);
    end else begin
      core_done = 1'b0;
    end
    if (spur_done) core_done = 1'b1;
    core_dataOut = spur_done ? 128'hdead_beef_dead_beef_dead_beef_dead_beef : core_pend;
  end

  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rsp_valid_onehot", 128'($countones(rsp_valid) <= 1), 128'(1));
      chk("req_ready_while_busy", 128'(busy && (req_ready != 2'b00)), 128'(0));
    end
  end

  task automatic set_row(input int i, input logic [1:0] vld, input int lat,
                         input int stall, input logic [1:0] gnt);
    vecs[i].vld     = vld;
    vecs[i].lat     = lat;
    vecs[i].stall   = stall;
    vecs[i].exp_gnt = gnt;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    chk({tag, "_rsp_data"}, rsp_data, 128'(0));
    chk({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
    chk({tag, "_core_start"}, 128'(core_start), 128'(0));
    chk({tag, "_core_dataIn"}, core_dataIn, 128'(0));
    chk({tag, "_core_resetn"}, 128'(core_resetn), 128'(0));
    chk({tag, "_key_bank"}, 128'(key_bank), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  // Entered on an IDLE negedge; returns on the IDLE negedge after the response handshake.
  task automatic run_job(input vec_t v, input int idx);
    exp_t         e;
    logic         g;
    logic [127:0] gdata;
    logic [127:0] held;
    logic [1:0]   held_v;
    int           n;
    int           starts;
    int           rst_lo;
    bit           bad;
    g     = v.exp_gnt[1];
    gdata = g ? v.d1 : v.d0;
    bad   = (v.lat == 0) || (v.lat > int'(TIMEOUT_CYC));
    core_lat = v.lat;
    req_data[0] = v.d0;
    req_data[1] = v.d1;
    req_valid   = v.vld;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("v%0d_grant", idx), 128'(req_ready), 128'(v.exp_gnt));
    e.g    = g;
    e.err  = bad;
    e.data = bad ? 128'(0) : aes_mock(gdata, g);
    sb.push_back(e);

    @(negedge clk);
    chk($sformatf("v%0d_start_pulse", idx), 128'(core_start), 128'(1));
    chk($sformatf("v%0d_key_bank", idx), 128'(key_bank), 128'(g));
    chk($sformatf("v%0d_core_dataIn", idx), core_dataIn, gdata);
    chk($sformatf("v%0d_busy", idx), 128'(busy), 128'(1));

    starts = 0;
    rst_lo = 0;
    n      = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && n < int'(TIMEOUT_CYC) + 100) begin
      if (core_start) starts++;
      if (!core_resetn) rst_lo++;
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_extra_start", idx), 128'(starts), 128'(0));
    chk($sformatf("v%0d_core_reset_len", idx), 128'(rst_lo), 128'(bad ? RST_CYC : 0));

    e = sb.pop_front();
    chk($sformatf("v%0d_rsp_valid", idx), 128'(rsp_valid), 128'(e.g ? 2'b10 : 2'b01));
    chk($sformatf("v%0d_rsp_data", idx), rsp_data, e.data);
    chk($sformatf("v%0d_rsp_err", idx), 128'(rsp_err), 128'(e.err));
    chk($sformatf("v%0d_key_bank_held", idx), 128'(key_bank), 128'(e.g));
    chk($sformatf("v%0d_dataIn_held", idx), core_dataIn, gdata);

    held   = rsp_data;
    held_v = rsp_valid;
    for (int s = 0; s < v.stall; s++) begin
      rsp_ready = (s == v.stall / 2) ? ~held_v : 2'b00;
      @(negedge clk);
      chk($sformatf("v%0d_bp_valid_c%0d", idx, s), 128'(rsp_valid), 128'(held_v));
      chk($sformatf("v%0d_bp_data_c%0d", idx, s), rsp_data, held);
      chk($sformatf("v%0d_bp_req_ready_c%0d", idx, s), 128'(req_ready), 128'(0));
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk($sformatf("v%0d_rsp_done", idx), 128'(rsp_valid), 128'(0));
    chk($sformatf("v%0d_idle", idx), 128'(busy), 128'(0));
  endtask

  initial begin
    logic [127:0] held;
    int           seen;
    vec_t         vr;

    resetn    = 1'b0;
    req_valid = 2'b00;
    req_data  = '0;
    rsp_ready = 2'b00;

    for (int i = 0; i < int'(NV); i++) begin
      vecs[i].d0 = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].d1 = {$urandom, $urandom, $urandom, $urandom};
    end
    vecs[0].d0 = PT_FIPS;
    set_row(0,  2'b01, 20,              0,  2'b01);
    set_row(1,  2'b11, 15,              0,  2'b10);
    set_row(2,  2'b11, 15,              0,  2'b01);
    set_row(3,  2'b11, 15,              0,  2'b10);
    set_row(4,  2'b11, 15,              0,  2'b01);
    set_row(5,  2'b01, 25,              20, 2'b01);
    set_row(6,  2'b10, 0,               0,  2'b10);
    set_row(7,  2'b10, 30,              0,  2'b10);
    set_row(8,  2'b11, TIMEOUT_CYC,     0,  2'b01);
    set_row(9,  2'b11, TIMEOUT_CYC + 1, 0,  2'b10);
    set_row(10, 2'b01, 5,               0,  2'b01);

    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    resetn = 1'b1;
    @(negedge clk);
    chk("por_core_resetn_release", 128'(core_resetn), 128'(1));
    chk("por_idle_busy", 128'(busy), 128'(0));
    mon_en = 1'b1;

    for (int i = 0; i < int'(NV); i++) run_job(vecs[i], i);
    req_valid = 2'b00;

    // Spurious done while idle must leave everything untouched.
    held = rsp_data;
    spur_done = 1'b1;
    repeat (2) @(negedge clk);
    spur_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_busy", 128'(busy), 128'(0));
    chk("spur_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("spur_rsp_data", rsp_data, held);
    chk("spur_core_start", 128'(core_start), 128'(0));

    // Reset in the middle of a job drops it silently.
    core_lat    = 200;
    req_data[0] = {$urandom, $urandom, $urandom, $urandom};
    req_valid   = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (10) @(negedge clk);
    chk("mid_busy_before_reset", 128'(busy), 128'(1));
    resetn = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid");
    @(negedge clk);
    chk("mid_core_resetn_hold", 128'(core_resetn), 128'(0));
    resetn = 1'b1;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen++;
    end
    chk("mid_no_response", 128'(seen), 128'(0));
    chk("mid_core_resetn_up", 128'(core_resetn), 128'(1));

    vr.vld     = 2'b11;
    vr.d0      = {$urandom, $urandom, $urandom, $urandom};
    vr.d1      = {$urandom, $urandom, $urandom, $urandom};
    vr.lat     = 10;
    vr.stall   = 0;
    vr.exp_gnt = 2'b01;
    run_job(vr, 99);
    req_valid = 2'b00;
    mon_en    = 1'b0;
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
